// File: rtl/inc_counter.sv
// -----------------------------------------------------------------------------
// inc_counter
//
// Purpose:
//   Loadable up-counter with a run-time terminal value. When the count reaches
//   the terminal value it either wraps to zero or saturates, depending on the
//   mode input. Wrapping raises a one-cycle terminal pulse and a sticky
//   overflow flag. Saturating raises the terminal pulse and parks the counter
//   in HALT until it is reloaded or reset.
//
// Ports:
//   Clk        in   1          clock; all state changes on the rising edge
//   Rst        in   1          asynchronous active-high reset
//   ld         in   1          synchronous load; takes priority over en
//   ld_val     in   DATAWIDTH  value loaded when ld=1
//   en         in   1          count enable
//   limit      in   DATAWIDTH  terminal value, sampled on every edge
//   sat        in   1          1 = saturate at limit, 0 = wrap to zero
//   clr_ovf    in   1          synchronous clear of ovf
//   d          out  DATAWIDTH  current count (registered)
//   tc         out  1          one-cycle terminal-count pulse (registered)
//   ovf        out  1          sticky wrap flag (registered)
//   busy       out  1          high while the FSM is in RUN (registered)
//   state_dbg  out  2          current FSM state, for observation only
//
// Handshake / timing:
//   There is no valid/ready handshake. ld and en are level requests sampled on
//   each rising edge; the edge that samples a request is the edge that updates
//   d, tc, ovf and busy. Every output comes straight from a flop, so there is
//   no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module inc_counter #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 ld,
    input  logic [DATAWIDTH-1:0] ld_val,
    input  logic                 en,
    input  logic [DATAWIDTH-1:0] limit,
    input  logic                 sat,
    input  logic                 clr_ovf,
    output logic [DATAWIDTH-1:0] d,
    output logic                 tc,
    output logic                 ovf,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   cnt_q,   cnt_d;
    logic                   tc_q,    tc_d;
    logic                   ovf_q,   ovf_d;
    logic                   busy_q,  busy_d;
    logic                   wrap;

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        wrap    = 1'b0;

        if (ld) begin
            // Load wins over counting from any state, including HALT.
            cnt_d   = ld_val;
            state_d = RUN;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    cnt_d   = cnt_q + DATAWIDTH'(1);
                    state_d = RUN;
                end
                RUN: begin
                    // Unsigned >= so a loaded value above limit terminates on
                    // the very next enabled edge instead of running past it.
                    if (cnt_q < limit) begin
                        cnt_d = cnt_q + DATAWIDTH'(1);
                    end else if (sat) begin
                        cnt_d   = limit;
                        tc_d    = 1'b1;
                        state_d = HALT;
                    end else begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                        wrap  = 1'b1;
                    end
                end
                HALT: begin
                    // Parked: only ld or Rst leave this state.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A wrap on the same edge as clr_ovf leaves the flag set, so no
        // overflow event can be lost to a coincident clear.
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign d         = cnt_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_inc_counter.sv
// -----------------------------------------------------------------------------
// tb_inc_counter
//
// Directed bench for inc_counter at DATAWIDTH=8. Each step pushes the
// expected {d, tc, ovf, busy} onto a queue, drives the inputs, lets one
// rising edge pass and pops/compares the registered outputs 1 time unit
// after the edge. Reset checks are taken between edges to show the reset
// acts without a clock.
// -----------------------------------------------------------------------------
module tb_inc_counter;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         tc;
        logic         ovf;
        logic         busy;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst;
    logic         ld;
    logic [W-1:0] ld_val;
    logic         en;
    logic [W-1:0] limit;
    logic         sat;
    logic         clr_ovf;
    logic [W-1:0] d;
    logic         tc;
    logic         ovf;
    logic         busy;
    logic [1:0]   state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inc_counter #(.DATAWIDTH(W)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .ld        (ld),
        .ld_val    (ld_val),
        .en        (en),
        .limit     (limit),
        .sat       (sat),
        .clr_ovf   (clr_ovf),
        .d         (d),
        .tc        (tc),
        .ovf       (ovf),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic push_exp(input logic [W-1:0] e_d, input logic e_tc,
                            input logic e_ovf, input logic e_busy);
        exp_t e;
        e.d    = e_d;
        e.tc   = e_tc;
        e.ovf  = e_ovf;
        e.busy = e_busy;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s queue: got empty want entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            assert (d === e.d) else begin
                n_fail++;
                $error("FAIL %s d: got %0h want %0h", tag, d, e.d);
            end
            n_cmp++;
            assert (tc === e.tc) else begin
                n_fail++;
                $error("FAIL %s tc: got %0b want %0b", tag, tc, e.tc);
            end
            n_cmp++;
            assert (ovf === e.ovf) else begin
                n_fail++;
                $error("FAIL %s ovf: got %0b want %0b", tag, ovf, e.ovf);
            end
            n_cmp++;
            assert (busy === e.busy) else begin
                n_fail++;
                $error("FAIL %s busy: got %0b want %0b", tag, busy, e.busy);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called just after an edge; drives inputs, waits one edge, checks.
    task automatic step(input logic i_ld, input logic [W-1:0] i_ld_val,
                        input logic i_en, input logic [W-1:0] i_limit,
                        input logic i_sat, input logic i_clr,
                        input logic [W-1:0] e_d, input logic e_tc,
                        input logic e_ovf, input logic e_busy,
                        input string tag);
        ld      = i_ld;
        ld_val  = i_ld_val;
        en      = i_en;
        limit   = i_limit;
        sat     = i_sat;
        clr_ovf = i_clr;
        push_exp(e_d, e_tc, e_ovf, e_busy);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    // Pulse reset between edges and confirm outputs clear without a clock.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        check_out(tag);
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst     = 1'b1;
        ld      = 1'b0;
        ld_val  = '0;
        en      = 1'b0;
        limit   = '0;
        sat     = 1'b0;
        clr_ovf = 1'b0;

        #3;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        check_out("por");
        @(posedge clk);
        #1;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        check_out("por_edge");
        rst = 1'b0;

        // Wrap mode, limit=3
        step(0, 8'h00, 1, 8'd3, 0, 0, 8'd1, 0, 0, 1, "wrap_e1");
        step(0, 8'h00, 1, 8'd3, 0, 0, 8'd2, 0, 0, 1, "wrap_e2");
        step(0, 8'h00, 1, 8'd3, 0, 0, 8'd3, 0, 0, 1, "wrap_e3");
        step(0, 8'h00, 1, 8'd3, 0, 0, 8'd0, 1, 1, 1, "wrap_e4");
        step(0, 8'h00, 1, 8'd3, 0, 0, 8'd1, 0, 1, 1, "wrap_e5");

        // Wrap coinciding with clr_ovf keeps ovf; a later clear drops it
        step(0, 8'h00, 1, 8'd3, 0, 0, 8'd2, 0, 1, 1, "clr_a");
        step(0, 8'h00, 1, 8'd3, 0, 0, 8'd3, 0, 1, 1, "clr_b");
        step(0, 8'h00, 1, 8'd3, 0, 1, 8'd0, 1, 1, 1, "clr_wrap");
        step(0, 8'h00, 1, 8'd3, 0, 1, 8'd1, 0, 0, 1, "clr_nowrap");

        // Saturate mode, limit=3
        do_reset("rst_sat");
        step(0, 8'h00, 1, 8'd3, 1, 0, 8'd1, 0, 0, 1, "sat_e1");
        step(0, 8'h00, 1, 8'd3, 1, 0, 8'd2, 0, 0, 1, "sat_e2");
        step(0, 8'h00, 1, 8'd3, 1, 0, 8'd3, 0, 0, 1, "sat_e3");
        step(0, 8'h00, 1, 8'd3, 1, 0, 8'd3, 1, 0, 0, "sat_e4");
        step(0, 8'h00, 1, 8'd3, 1, 0, 8'd3, 0, 0, 0, "sat_e5");
        step(0, 8'h00, 0, 8'd3, 1, 0, 8'd3, 0, 0, 0, "halt_hold");

        // Load out of HALT beats en on the same edge
        step(1, 8'h10, 1, 8'h20, 1, 0, 8'h10, 0, 0, 1, "halt_ld");
        step(0, 8'h00, 1, 8'h20, 1, 0, 8'h11, 0, 0, 1, "halt_ld_inc");

        // All-ones limit wraps modulo 2^8
        step(1, 8'hFE, 0, 8'hFF, 0, 0, 8'hFE, 0, 0, 1, "max_ld");
        step(0, 8'h00, 1, 8'hFF, 0, 0, 8'hFF, 0, 0, 1, "max_e1");
        step(0, 8'h00, 1, 8'hFF, 0, 0, 8'h00, 1, 1, 1, "max_e2");

        // limit=0: every enabled edge is terminal
        step(0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 1, 1, "lim0_e1");
        step(0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 1, 1, "lim0_e2");
        step(0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 1, 1, 1, "lim0_e3");
        step(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, "lim0_idle");

        // Load leaves ovf alone; ld_val above limit terminates next edge
        step(1, 8'h09, 0, 8'h02, 0, 0, 8'h09, 0, 1, 1, "ld_keep_ovf");
        step(0, 8'h00, 1, 8'h02, 0, 0, 8'h00, 1, 1, 1, "ld_above_lim");
        step(0, 8'h00, 0, 8'h02, 0, 1, 8'h00, 0, 0, 1, "clr_only");

        // Limit lowered mid-count takes effect on that edge
        step(0, 8'h00, 1, 8'h05, 0, 0, 8'h01, 0, 0, 1, "lim_chg_a");
        step(0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 1, 1, 1, "lim_chg_b");

        // Asynchronous reset between edges at d=5 with ovf set
        step(1, 8'h05, 0, 8'h20, 0, 0, 8'h05, 0, 1, 1, "pre_rst_ld");
        en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        check_out("async_rst");
        @(posedge clk);
        #1;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        check_out("rst_held_edge");
        rst = 1'b0;
        step(0, 8'h00, 1, 8'h20, 0, 0, 8'h01, 0, 0, 1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inc_counter.md
INC_COUNTER -- requirements
Module: inc_counter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 64, giving the width of the count, load value and limit.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ld, input, 1, synchronous load request.
REQ-005 SHALL have port ld_val, input, DATAWIDTH, the value loaded when ld=1.
REQ-006 SHALL have port en, input, 1, count-enable request.
REQ-007 SHALL have port limit, input, DATAWIDTH, the terminal value, sampled every edge.
REQ-008 SHALL have port sat, input, 1, the mode: 1 = saturate at limit, 0 = wrap to 0.
REQ-009 SHALL have port clr_ovf, input, 1, synchronous clear of ovf.
REQ-010 SHALL have port d, output reg, DATAWIDTH, the current count.
REQ-011 SHALL have port tc, output reg, 1, one-cycle terminal-count pulse.
REQ-012 SHALL have port ovf, output reg, 1, sticky wrap flag.
REQ-013 SHALL have port busy, output reg, 1, high while in state RUN.

Function
REQ-014 SHALL implement states IDLE, RUN and HALT, with the registered state driving busy.
REQ-015 SHALL give ld priority over en: when ld=1, d <= ld_val and tc <= 0, and the state goes to RUN, regardless of en or the current state.
REQ-016 SHALL, in IDLE with en=1 and ld=0, increment d and go to RUN.
REQ-017 SHALL, with en=0 and ld=0, hold d and the state, with tc <= 0.
REQ-018 SHALL, in RUN with en=1, ld=0 and d < limit (unsigned), set d <= d + 1 and tc <= 0.
REQ-019 SHALL, in RUN with en=1, ld=0, d >= limit (unsigned) and sat=0, set d <= 0, tc <= 1 and ovf <= 1, and stay in RUN.
REQ-020 SHALL, in RUN with en=1, ld=0, d >= limit (unsigned) and sat=1, set d <= limit and tc <= 1, and go to HALT.
REQ-021 SHALL, in HALT, hold d and keep tc = 0 for any en; the only exits are ld or Rst.
REQ-022 SHALL use one-cycle latency: the edge that samples en=1 is the edge that updates d, tc and ovf; there is no combinational path from inputs to outputs.
REQ-023 SHALL compute all arithmetic modulo 2^DATAWIDTH, so limit = all-ones and d = all-ones with sat=0 wraps to 0 with tc=1.
REQ-024 SHALL, when ld_val > limit is loaded, treat the next enabled increment as the terminal case (REQ-019 or REQ-020).
REQ-025 SHALL pulse tc for exactly one cycle per terminal event; back-to-back terminal events (limit=0, sat=0, en held) give tc=1 on every enabled cycle.
REQ-026 SHALL clear ovf when clr_ovf=1; when a wrap and clr_ovf occur on the same edge, the set wins and ovf stays 1.
REQ-027 SHALL NOT change ovf on ld.
REQ-028 SHALL use the limit value sampled at the edge; a limit change mid-count takes effect on that edge.

Reset
REQ-029 SHALL, while Rst=1, immediately and independent of Clk, force d=0, tc=0, ovf=0, busy=0 and state IDLE.
REQ-030 SHALL, on Rst asserted mid-count or in HALT, abandon the operation with no tc pulse; the first edge after release obeys REQ-015 to REQ-017.

Verification (DATAWIDTH=8)
REQ-031 SHALL cover: Rst pulse then en=1, limit=3, sat=0 for 5 edges -> d = 1,2,3,0,1; tc=1 only with d=0; ovf=1 from then on; busy=1 from the first edge.
REQ-032 SHALL cover: limit=3, sat=1, en held for 5 edges -> d = 1,2,3,3,3; tc=1 for one cycle when d first shows 3 after the terminal edge; busy=0 in HALT.
REQ-033 SHALL cover: in HALT, ld=1, ld_val=0x10, limit=0x20 with en=1 on the same edge -> d=0x10 (load wins), busy=1; next en edge gives d=0x11.
REQ-034 SHALL cover: limit=0xFF, ld_val=0xFE, sat=0, then en for 2 edges -> d = 0xFF, 0x00; tc=1 and ovf=1 on the second edge.
REQ-035 SHALL cover: a wrap edge with clr_ovf=1 -> ovf=1; next edge with clr_ovf=1 and no wrap -> ovf=0.
REQ-036 SHALL cover: Rst asserted between edges at d=0x05 -> d=0, ovf=0, busy=0 before the next Clk edge; no tc pulse.
